uoram_request_stager: RTL and testbench
=======================================

// Module: uoram_request_stager
// PURPOSE
//  Client-side staging stage directly upstream of the unified ORAM controller. Buffers client
//  commands and program (write) data independently, and releases a command only once its full data
//  block is held, so the controller never stalls mid-access waiting on the network. Data may arrive
//  before or after its command. Also frames read-return data with a last-beat flag for the client.
// PARAMETERS
//  ORAMU       32   program block address width
//  ORAMB       512  data block size in bits
//  FEDWidth    64   frontend data chunk width; Chunks = divceil(ORAMB, FEDWidth) (8 at defaults)
//  BECMDWidth  2    backend command width (shared backend command constants)
//  DMWidth     8    write-mask width
//  CmdDepth    4    command FIFO entries (power of 2, >=2)
//  DataBlocks  2    whole data blocks held in data buffer (buffer = DataBlocks*Chunks chunks)
// PORTS
//  Clock            in   1           clock
//  Reset            in   1           synchronous, active-low reset
//  ClientCmdReady   out  1           command accept
//  ClientCmdValid   in   1           command valid
//  ClientCmd        in   BECMDWidth  command
//  ClientAddr       in   ORAMU       program block address
//  ClientWMask      in   DMWidth     write mask
//  ClientDataReady  out  1           data chunk accept
//  ClientDataValid  in   1           data chunk valid
//  ClientData       in   FEDWidth    data chunk
//  CmdOutReady      in   1           controller command accept
//  CmdOutValid      out  1           command to controller valid
//  CmdOut           out  BECMDWidth  command to controller
//  AddrOut          out  ORAMU       address to controller
//  WMaskOut         out  DMWidth     mask to controller
//  DataOutReady     in   1           controller data accept
//  DataOutValid     out  1           data chunk to controller valid
//  DataOut          out  FEDWidth    data chunk to controller
//  RetInReady       out  1           = RetOutReady (pass-through)
//  RetInValid       in   1           return chunk from controller valid
//  RetIn            in   FEDWidth    return chunk from controller
//  RetOutReady      in   1           client return accept
//  RetOutValid      out  1           = RetInValid
//  RetOut           out  FEDWidth    = RetIn
//  RetOutLast       out  1           high on chunk Chunks-1 of each returned block
//  BlocksReady      out  clog2(DataBlocks+1)  complete, unconsumed data blocks held
// BEHAVIOUR
//  Reset (Reset==0 at an edge): FIFOs empty; all counters 0; FSM=IDLE; CmdOutValid, DataOutValid,
//   ClientCmdReady, ClientDataReady, RetOutLast =0; BlocksReady=0. Reset mid-stream flushes all
//   state; partially sent blocks are not resumed. Outputs valid one cycle after Reset returns high.
//  NeedsData(cmd) is true for write and append, false for read and read-remove.
//  Cmd FIFO: ClientCmdReady = !full. Push on ClientCmdValid&&ClientCmdReady; fall-through head.
//  Data FIFO: ClientDataReady = !full. InCnt counts accepted chunks 0..Chunks-1 and wraps; on accept
//   with InCnt==Chunks-1, BlocksReady+1. Issuing a NeedsData command decrements BlocksReady.
//   Increment and decrement in the same cycle leave BlocksReady unchanged.
//  FSM IDLE -> ISSUE when cmd FIFO is non-empty and (!NeedsData(head) || BlocksReady!=0).
//   CmdOutValid=1 only in ISSUE; outputs driven from FIFO head and held stable until handshake.
//  ISSUE, on CmdOutReady: pop cmd. If NeedsData, -> STREAM with OutCnt=0; otherwise -> IDLE.
//   The earliest next CmdOutValid is the cycle after IDLE; there is no IDLE->ISSUE bypass.
//  STREAM: DataOutValid = data FIFO non-empty (always true, block is whole). On each handshake,
//   pop and OutCnt+1. On handshake with OutCnt==Chunks-1 -> IDLE. Commands never issue in STREAM.
//  Ordering: the nth NeedsData command consumes the nth complete block. Reads may overtake no one:
//   strict FIFO order across all commands.
//  Latency: command with data already held: push at cycle t -> CmdOutValid at t+2.
//  Return path is combinational pass-through. RetCnt counts RetIn handshakes mod Chunks;
//   RetOutLast = RetInValid && RetCnt==Chunks-1.
//  Simultaneous push and pop on either FIFO while full is not allowed, because Ready is low when
//   full. Simultaneous push and pop while non-full are both performed.
// TESTING
//  Write cmd then 8 chunks 0x11..0x18 -> CmdOutValid at or after chunk 8 accept; DataOut 0x11..0x18.
//  8 chunks, idle 20 cycles, then write cmd -> CmdOutValid 2 cycles after cmd accept; BlocksReady 1->0.
//  Read, write, read pushed back-to-back with CmdOutReady=1, write data late -> issue order kept;
//   second read waits for write STREAM to end.
//  Fill data FIFO (16 chunks), no cmd -> ClientDataReady=0, BlocksReady=2; one write -> Ready returns.
//  16 return chunks with RetOutReady toggling -> RetOutLast on beats 8 and 16 only; no beats lost.
//  Reset low during STREAM at chunk 3 -> next cycle all valids 0, BlocksReady=0, FIFOs empty.

Source files
------------

// File: rtl/uoram_request_stager.sv
// Client-side staging in front of the unified ORAM controller: a command is held back until its
// whole write block is buffered, and read-return beats are framed with a last-beat flag.

// Generic synchronous FIFO whose head is visible on OutData without a read request.
// Latency: an accepted push appears at the head on the following cycle.
// Backpressure: InReady is low when full, OutValid is low when empty.
module uoram_stager_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [Width-1:0] InData,
   input  logic             InValid,
   output logic             InReady,
   output logic [Width-1:0] OutData,
   output logic             OutValid,
   input  logic             OutReady
);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wrPtr, rdPtr;
   logic [CntW-1:0]  count;
   logic             push, pop;

   assign InReady  = (count != CntW'(Depth));
   assign OutValid = (count != '0);
   assign OutData  = mem[rdPtr];
   assign push     = InValid && InReady;
   assign pop      = OutValid && OutReady;

   function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge Clock) begin
      if (push) mem[wrPtr] <= InData;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= nextPtr(wrPtr);
         if (pop)  rdPtr <= nextPtr(rdPtr);
         case ({push, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: ;
         endcase
      end
   end
endmodule

// Orders client commands and write data so a write only reaches the controller with its block held.
// Latency: a command whose data is already buffered is presented two cycles after it is accepted.
// Backpressure: client readies drop when the respective FIFO is full; outputs hold until accepted.
module uoram_request_stager #(
   parameter int ORAMU      = 32,
   parameter int ORAMB      = 512,
   parameter int FEDWidth   = 64,
   parameter int BECMDWidth = 2,
   parameter int DMWidth    = 8,
   parameter int CmdDepth   = 4,
   parameter int DataBlocks = 2
) (
   input  logic                              Clock,
   input  logic                              Reset,
   output logic                              ClientCmdReady,
   input  logic                              ClientCmdValid,
   input  logic [BECMDWidth-1:0]             ClientCmd,
   input  logic [ORAMU-1:0]                  ClientAddr,
   input  logic [DMWidth-1:0]                ClientWMask,
   output logic                              ClientDataReady,
   input  logic                              ClientDataValid,
   input  logic [FEDWidth-1:0]               ClientData,
   input  logic                              CmdOutReady,
   output logic                              CmdOutValid,
   output logic [BECMDWidth-1:0]             CmdOut,
   output logic [ORAMU-1:0]                  AddrOut,
   output logic [DMWidth-1:0]                WMaskOut,
   input  logic                              DataOutReady,
   output logic                              DataOutValid,
   output logic [FEDWidth-1:0]               DataOut,
   output logic                              RetInReady,
   input  logic                              RetInValid,
   input  logic [FEDWidth-1:0]               RetIn,
   input  logic                              RetOutReady,
   output logic                              RetOutValid,
   output logic [FEDWidth-1:0]               RetOut,
   output logic                              RetOutLast,
   output logic [$clog2(DataBlocks+1)-1:0]   BlocksReady
);
   localparam int Chunks = (ORAMB + FEDWidth - 1) / FEDWidth;
   localparam int CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
   localparam int BlkW   = $clog2(DataBlocks + 1);
   localparam logic [CntW-1:0]       LastChunk = CntW'(Chunks - 1);
   localparam logic [BECMDWidth-1:0] CmdUpdate = BECMDWidth'(0);
   localparam logic [BECMDWidth-1:0] CmdAppend = BECMDWidth'(1);

   typedef struct packed {
      logic [BECMDWidth-1:0] cmd;
      logic [ORAMU-1:0]      addr;
      logic [DMWidth-1:0]    wMask;
   } cmdEntry_t;

   typedef enum logic [1:0] {StIdle, StIssue, StStream} state_t;

   state_t              state, stateNext;
   cmdEntry_t           cmdIn, cmdHead;
   logic                cmdInReady, cmdHeadValid, cmdPop, cmdAccept;
   logic                dataInReady, dataHeadValid, dataPop, dataAccept;
   logic [FEDWidth-1:0] dataHead;
   logic [CntW-1:0]     inCnt, outCnt, retCnt;
   logic                headNeedsData, blockDone, blockTaken;

   assign cmdIn           = '{cmd: ClientCmd, addr: ClientAddr, wMask: ClientWMask};
   assign ClientCmdReady  = Reset && cmdInReady;
   assign ClientDataReady = Reset && dataInReady;
   assign cmdAccept       = ClientCmdValid && ClientCmdReady;
   assign dataAccept      = ClientDataValid && ClientDataReady;

   uoram_stager_fifo #(.Width($bits(cmdEntry_t)), .Depth(CmdDepth)) cmdFifo (
      .Clock(Clock), .Reset(Reset),
      .InData(cmdIn), .InValid(cmdAccept), .InReady(cmdInReady),
      .OutData(cmdHead), .OutValid(cmdHeadValid), .OutReady(cmdPop)
   );

   uoram_stager_fifo #(.Width(FEDWidth), .Depth(DataBlocks * Chunks)) dataFifo (
      .Clock(Clock), .Reset(Reset),
      .InData(ClientData), .InValid(dataAccept), .InReady(dataInReady),
      .OutData(dataHead), .OutValid(dataHeadValid), .OutReady(dataPop)
   );

   assign headNeedsData = (cmdHead.cmd == CmdUpdate) || (cmdHead.cmd == CmdAppend);
   assign CmdOut        = cmdHead.cmd;
   assign AddrOut       = cmdHead.addr;
   assign WMaskOut      = cmdHead.wMask;
   assign DataOut       = dataHead;
   assign blockDone     = dataAccept && (inCnt == LastChunk);
   assign blockTaken    = cmdPop && headNeedsData;

   always_comb begin
      stateNext    = state;
      CmdOutValid  = 1'b0;
      DataOutValid = 1'b0;
      cmdPop       = 1'b0;
      dataPop      = 1'b0;
      case (state)
         StIdle: begin
            if (cmdHeadValid && (!headNeedsData || BlocksReady != '0)) stateNext = StIssue;
         end
         StIssue: begin
            CmdOutValid = 1'b1;
            if (CmdOutReady) begin
               cmdPop    = 1'b1;
               stateNext = headNeedsData ? StStream : StIdle;
            end
         end
         StStream: begin
            DataOutValid = dataHeadValid;
            if (dataHeadValid && DataOutReady) begin
               dataPop = 1'b1;
               if (outCnt == LastChunk) stateNext = StIdle;
            end
         end
         default: stateNext = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state       <= StIdle;
         inCnt       <= '0;
         outCnt      <= '0;
         retCnt      <= '0;
         BlocksReady <= '0;
      end else begin
         state <= stateNext;
         if (dataAccept) inCnt <= (inCnt == LastChunk) ? '0 : inCnt + CntW'(1);
         if (blockTaken)   outCnt <= '0;
         else if (dataPop) outCnt <= outCnt + CntW'(1);
         if (RetInValid && RetOutReady) retCnt <= (retCnt == LastChunk) ? '0 : retCnt + CntW'(1);
         // a block completing and a block being claimed in one cycle cancel out
         case ({blockDone, blockTaken})
            2'b10:   BlocksReady <= BlocksReady + BlkW'(1);
            2'b01:   BlocksReady <= BlocksReady - BlkW'(1);
            default: ;
         endcase
      end
   end

   assign RetInReady  = RetOutReady;
   assign RetOutValid = RetInValid;
   assign RetOut      = RetIn;
   assign RetOutLast  = RetInValid && (retCnt == LastChunk);
endmodule

// File: tb/tb_uoram_request_stager.sv
// Scoreboard bench: accepted client traffic is queued as expectation, a negedge monitor checks it.
`timescale 1ns/1ps
module tb_uoram_request_stager;
   localparam int Chunks = 8;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [7:0]  mask;
   } cmd_t;

   logic        Clock, Reset;
   logic        ClientCmdReady, ClientCmdValid;
   logic [1:0]  ClientCmd;
   logic [31:0] ClientAddr;
   logic [7:0]  ClientWMask;
   logic        ClientDataReady, ClientDataValid;
   logic [63:0] ClientData;
   logic        CmdOutReady, CmdOutValid;
   logic [1:0]  CmdOut;
   logic [31:0] AddrOut;
   logic [7:0]  WMaskOut;
   logic        DataOutReady, DataOutValid;
   logic [63:0] DataOut;
   logic        RetInReady, RetInValid;
   logic [63:0] RetIn;
   logic        RetOutReady, RetOutValid;
   logic [63:0] RetOut;
   logic        RetOutLast;
   logic [1:0]  BlocksReady;

   uoram_request_stager dut (
      .Clock(Clock), .Reset(Reset),
      .ClientCmdReady(ClientCmdReady), .ClientCmdValid(ClientCmdValid), .ClientCmd(ClientCmd),
      .ClientAddr(ClientAddr), .ClientWMask(ClientWMask),
      .ClientDataReady(ClientDataReady), .ClientDataValid(ClientDataValid), .ClientData(ClientData),
      .CmdOutReady(CmdOutReady), .CmdOutValid(CmdOutValid), .CmdOut(CmdOut),
      .AddrOut(AddrOut), .WMaskOut(WMaskOut),
      .DataOutReady(DataOutReady), .DataOutValid(DataOutValid), .DataOut(DataOut),
      .RetInReady(RetInReady), .RetInValid(RetInValid), .RetIn(RetIn),
      .RetOutReady(RetOutReady), .RetOutValid(RetOutValid), .RetOut(RetOut),
      .RetOutLast(RetOutLast), .BlocksReady(BlocksReady)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   cmd_t        cmdQ[$];
   logic [63:0] dataQ[$];
   cmd_t        expC;
   int checks = 0, errors = 0;
   int chunksIn = 0, needIssued = 0, streamLeft = 0, retCnt = 0, retBeats = 0, retLasts = 0;
   bit rndReady = 0, retToggle = 0;

   function automatic bit needsData(input logic [1:0] c);
      return (c == 2'd0) || (c == 2'd1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // reference model: strict FIFO order, nth write-type command owns the nth whole block
   always @(negedge Clock) begin
      if (!Reset) begin
         cmdQ.delete();
         dataQ.delete();
         chunksIn = 0; needIssued = 0; streamLeft = 0; retCnt = 0;
      end else begin
         check("blocks_ready", 64'(BlocksReady), 64'(chunksIn / Chunks - needIssued));
         check("ret_ready_pass", 64'(RetInReady), 64'(RetOutReady));
         if (DataOutValid) begin
            check("data_only_in_stream", 64'(streamLeft > 0), 64'(1));
            if (DataOutReady) begin
               if (dataQ.size() == 0) failNow("data_unexpected");
               else check("data_out", DataOut, dataQ.pop_front());
               if (streamLeft > 0) streamLeft--;
            end
         end
         if (CmdOutValid) begin
            check("cmd_not_in_stream", 64'(streamLeft), 64'(0));
            if (CmdOutReady) begin
               if (cmdQ.size() == 0) failNow("cmd_unexpected");
               else begin
                  expC = cmdQ.pop_front();
                  check("cmd_out", 64'({CmdOut, AddrOut, WMaskOut}), 64'(expC));
                  if (needsData(expC.cmd)) begin
                     check("block_held", 64'((chunksIn / Chunks - needIssued) > 0), 64'(1));
                     needIssued++;
                     streamLeft = Chunks;
                  end
               end
            end
         end
         if (RetInValid) begin
            check("ret_valid", 64'(RetOutValid), 64'(1));
            check("ret_data", RetOut, RetIn);
            check("ret_last", 64'(RetOutLast), 64'(retCnt == Chunks - 1));
            if (RetOutReady) begin
               retBeats++;
               if (RetOutLast) retLasts++;
               retCnt = (retCnt + 1) % Chunks;
            end
         end else check("ret_last_idle", 64'(RetOutLast), 64'(0));
         if (ClientCmdValid && ClientCmdReady) cmdQ.push_back('{ClientCmd, ClientAddr, ClientWMask});
         if (ClientDataValid && ClientDataReady) begin
            dataQ.push_back(ClientData);
            chunksIn++;
         end
      end
   end

   always @(posedge Clock) begin
      #1;
      if (rndReady) begin
         CmdOutReady  = 1'($urandom_range(0, 1));
         DataOutReady = 1'($urandom_range(0, 1));
      end
      if (retToggle) RetOutReady = 1'($urandom_range(0, 1));
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge Clock); #1; end
   endtask

   task automatic sendCmd(input logic [1:0] c, input logic [31:0] a, input logic [7:0] m);
      int n = 0;
      ClientCmdValid = 1'b1; ClientCmd = c; ClientAddr = a; ClientWMask = m;
      do begin @(negedge Clock); n++; end while (!ClientCmdReady && n < 3000);
      if (!ClientCmdReady) failNow("cmd_accept_timeout");
      @(posedge Clock); #1;
      ClientCmdValid = 1'b0;
   endtask

   task automatic sendChunk(input logic [63:0] d);
      int n = 0;
      ClientDataValid = 1'b1; ClientData = d;
      do begin @(negedge Clock); n++; end while (!ClientDataReady && n < 3000);
      if (!ClientDataReady) failNow("data_accept_timeout");
      @(posedge Clock); #1;
      ClientDataValid = 1'b0;
   endtask

   task automatic sendRet(input logic [63:0] d);
      int n = 0;
      RetInValid = 1'b1; RetIn = d;
      do begin @(negedge Clock); n++; end while (!RetInReady && n < 3000);
      if (!RetInReady) failNow("ret_accept_timeout");
      @(posedge Clock); #1;
      RetInValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      do begin @(negedge Clock); n++; end
      while ((cmdQ.size() != 0 || dataQ.size() != 0 || streamLeft != 0) && n < 3000);
      check("drained", 64'(cmdQ.size() + dataQ.size() + streamLeft), 64'(0));
      @(posedge Clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t cmds[24];
      int   nWrites, n, rb, rl;
      Reset = 1'b0;
      ClientCmdValid = 0; ClientCmd = 0; ClientAddr = 0; ClientWMask = 0;
      ClientDataValid = 0; ClientData = 0; CmdOutReady = 0; DataOutReady = 0;
      RetInValid = 0; RetIn = 0; RetOutReady = 0;
      tick(3);
      @(negedge Clock);
      check("rst_cmd_valid", 64'(CmdOutValid), 64'(0));
      check("rst_data_valid", 64'(DataOutValid), 64'(0));
      check("rst_cmd_ready", 64'(ClientCmdReady), 64'(0));
      check("rst_data_ready", 64'(ClientDataReady), 64'(0));
      check("rst_blocks", 64'(BlocksReady), 64'(0));
      check("rst_last", 64'(RetOutLast), 64'(0));
      @(posedge Clock); #1;
      Reset = 1'b1;
      CmdOutReady = 1'b1; DataOutReady = 1'b1;

      // write command ahead of its data
      sendCmd(2'd0, 32'h100, 8'hFF);
      for (int i = 0; i < Chunks; i++) sendChunk(64'(8'h11 + i));
      drain();

      // data first, then command: fixed two-cycle issue latency
      for (int i = 0; i < Chunks; i++) sendChunk(64'(8'h21 + i));
      tick(20);
      @(negedge Clock);
      check("blocks_one", 64'(BlocksReady), 64'(1));
      @(posedge Clock); #1;
      sendCmd(2'd1, 32'h200, 8'h0F);
      n = 0;
      do begin @(negedge Clock); n++; end while (!CmdOutValid && n < 20);
      check("issue_latency", 64'(n), 64'(2));
      @(posedge Clock); #1;
      drain();

      // read, write, read with late write data
      sendCmd(2'd2, 32'h300, 8'h01);
      sendCmd(2'd0, 32'h301, 8'h02);
      sendCmd(2'd3, 32'h302, 8'h03);
      tick(10);
      for (int i = 0; i < Chunks; i++) sendChunk({32'hA5A5_0000, 32'(i)});
      drain();

      // fill the data buffer with no command
      for (int i = 0; i < 2 * Chunks; i++) sendChunk(64'(16'h4000 + i));
      @(negedge Clock);
      check("full_data_ready", 64'(ClientDataReady), 64'(0));
      check("full_blocks", 64'(BlocksReady), 64'(2));
      @(posedge Clock); #1;
      sendCmd(2'd0, 32'h400, 8'hAA);
      n = 0;
      do begin @(negedge Clock); n++; end while (!ClientDataReady && n < 50);
      check("ready_returns", 64'(ClientDataReady), 64'(1));
      @(posedge Clock); #1;
      sendCmd(2'd1, 32'h401, 8'h55);
      drain();

      // return path under random client backpressure
      rb = retBeats; rl = retLasts;
      retToggle = 1;
      for (int i = 0; i < 2 * Chunks; i++) sendRet({$urandom, $urandom});
      retToggle = 0;
      tick(1);
      check("ret_beats", 64'(retBeats - rb), 64'(2 * Chunks));
      check("ret_lasts", 64'(retLasts - rl), 64'(2));

      // random mix with random controller backpressure
      nWrites = 0;
      for (int i = 0; i < 24; i++) begin
         cmds[i] = '{2'($urandom_range(0, 3)), $urandom, 8'($urandom)};
         if (needsData(cmds[i].cmd)) nWrites++;
      end
      rndReady = 1;
      fork
         for (int i = 0; i < 24; i++) begin
            tick($urandom_range(0, 3));
            sendCmd(cmds[i].cmd, cmds[i].addr, cmds[i].mask);
         end
         for (int j = 0; j < nWrites * Chunks; j++) begin
            tick($urandom_range(0, 2));
            sendChunk({$urandom, $urandom});
         end
      join
      rndReady = 0;
      tick(1);
      CmdOutReady = 1'b1; DataOutReady = 1'b1;
      drain();

      // reset in the middle of a stream
      DataOutReady = 1'b0;
      sendCmd(2'd0, 32'h500, 8'hC3);
      for (int i = 0; i < 2 * Chunks; i++) sendChunk(64'(16'h5000 + i));
      n = 0;
      do begin @(negedge Clock); n++; end while (!DataOutValid && n < 50);
      check("stream_started", 64'(DataOutValid), 64'(1));
      @(posedge Clock); #1;
      DataOutReady = 1'b1;
      tick(3);
      DataOutReady = 1'b0;
      Reset = 1'b0;
      tick(1);
      @(negedge Clock);
      check("mid_rst_cmd_valid", 64'(CmdOutValid), 64'(0));
      check("mid_rst_data_valid", 64'(DataOutValid), 64'(0));
      check("mid_rst_blocks", 64'(BlocksReady), 64'(0));
      @(posedge Clock); #1;
      Reset = 1'b1;
      CmdOutReady = 1'b1; DataOutReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         check("flushed_cmd_valid", 64'(CmdOutValid), 64'(0));
         check("flushed_data_valid", 64'(DataOutValid), 64'(0));
         check("flushed_data_ready", 64'(ClientDataReady), 64'(1));
      end
      @(posedge Clock); #1;
      sendCmd(2'd2, 32'h600, 8'h11);
      sendCmd(2'd0, 32'h601, 8'h22);
      for (int i = 0; i < Chunks; i++) sendChunk(64'(16'h6000 + i));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
